// File: rtl/mdu_seq_if.sv
// mdu_seq_if: operand/result bundle between the EX stage and the
// multi-cycle multiply/divide sequencer.
//
// Handshake: start is honoured only while busy is low and cancel is low.
// It is a request with no ready: if the unit is busy, the request is dropped
// rather than held. done is a single-cycle pulse that qualifies hi/lo (and
// div_by_zero). busy stays high from the accepting edge until the cycle
// that shows done.
interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues requests, observes results.
    modport master (
        output start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    // Sequencer side.
    modport slave (
        input  start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply / restoring divide unit that owns HI/LO.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Signed operations run on operand
// magnitudes and apply sign correction in FIXUP.
// Optional feature macro: MDU_EARLY_OUT_EN -- a multiply leaves CALC as soon
// as the remaining multiplier bits are zero (results unchanged, latency
// variable). Undefined: every multiply takes WIDTH iterations.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    mdu_seq_if.slave   bus,
    output logic [1:0] dbg_state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Multiply: remaining multiplier bits (shifted right each iteration).
    // Divide: dividend shifting out at the top, quotient shifting in below.
    logic [WIDTH-1:0]   mpl_q, mpl_d;
    // Multiply: multiplicand shifted left each iteration. Divide: divisor.
    logic [2*WIDTH-1:0] mcd_q, mcd_d;
    // Multiply: running product. Divide: partial remainder in the low half.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Signed ops work on magnitudes; op[0]=1 means unsigned.
    assign abs_a = (!bus.op[0] && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    assign abs_b = (!bus.op[0] && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

    // Restoring step: bring down the next dividend bit, subtract if it fits.
    // When it fits the true difference is below 2^WIDTH, so the low bits suffice.
    assign div_shift = {acc_q[WIDTH-1:0], mpl_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mcd_q[WIDTH-1:0]});
    assign div_diff  = div_shift[WIDTH-1:0] - mcd_q[WIDTH-1:0];

    // Sign-corrected results; 0x80000000 / -1 wraps naturally here.
    assign prod_fix = neg_q     ? -acc_q            : acc_q;
    assign quo_fix  = neg_q     ? -mpl_q            : mpl_q;
    assign rem_fix  = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    // Next-state logic: accept/latch in IDLE, iterate in CALC, write in FIXUP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mpl_d     = mpl_q;
        mcd_d     = mcd_q;
        acc_d     = acc_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                // cancel in IDLE suppresses a coincident start.
                if (bus.start && !bus.cancel) begin
                    is_div_d  = bus.op[1];
                    neg_d     = !bus.op[0] && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                    neg_rem_d = !bus.op[0] && bus.src_a[WIDTH-1];
                    cnt_d     = '0;
                    acc_d     = '0;
                    dz_d      = 1'b0;
                    state_d   = S_CALC;
                    if (bus.op[1]) begin
                        mpl_d = abs_a;
                        mcd_d = {{WIDTH{1'b0}}, abs_b};
                        if (bus.src_b == '0) begin
                            dz_d    = 1'b1;
                            state_d = S_FIXUP;
                        end
                    end else begin
                        mpl_d = abs_b;
                        mcd_d = {{WIDTH{1'b0}}, abs_a};
`ifdef MDU_EARLY_OUT_EN
                        if (bus.src_b == '0) state_d = S_FIXUP;
`endif
                    end
                end
            end

            S_CALC: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        if (div_ge) acc_d = {{WIDTH{1'b0}}, div_diff};
                        else        acc_d = {{WIDTH{1'b0}}, div_shift[WIDTH-1:0]};
                        mpl_d = {mpl_q[WIDTH-2:0], div_ge};
                    end else begin
                        if (mpl_q[0]) acc_d = acc_q + mcd_q;
                        mcd_d = mcd_q << 1;
                        mpl_d = mpl_q >> 1;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_FIXUP;
                    end
`ifdef MDU_EARLY_OUT_EN
                    else if (!is_div_q && ((mpl_q >> 1) == '0)) begin
                        state_d = S_FIXUP;
                    end
`endif
                end
            end

            S_FIXUP: begin
                state_d = S_IDLE;
                if (!bus.cancel) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        dbz_d = 1'b1;
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; async reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mpl_q     <= '0;
            mcd_q     <= '0;
            acc_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mpl_q     <= mpl_d;
            mcd_q     <= mcd_d;
            acc_q     <= acc_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign dbg_state_o     = state_q;

endmodule
